ins_loader: RTL

INS_LOADER -- requirements
Module: ins_loader

---
 rtl/ins_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/ins_loader.sv
// Instruction loader: streams program bytes from a host into instruction
// memory while holding the processor in reset. It releases the processor once
// the end-of-program opcode has been written. If the memory fills up before
// that opcode arrives, it flags an overflow instead.
module ins_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  ENDOP  = 8'd28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              overflow_err,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_W:0]   COUNT_ONE = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              handshake;

  // A byte is only ever accepted while loading.
  assign handshake = (state_q == LOAD) && in_valid;

  // Next-state logic: accept bytes, track the write address, and decide when the load ends.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      LOAD: begin
        if (handshake) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = in_data;
          count_d = count_q + COUNT_ONE;
          // ENDOP wins even at the last address, so it is checked first.
          if (in_data == ENDOP) begin
            state_d = DONE;
          end else if (addr_q == LAST_ADDR) begin
            state_d = ERR;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and write-port registers; the memory write lags the handshake by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready     = (state_q == LOAD);
  assign cpu_rst_n    = (state_q == DONE);
  assign load_done    = (state_q == DONE);
  assign overflow_err = (state_q == ERR);
  assign byte_count   = count_q;
  assign mem_we       = we_q;
  assign mem_addr     = waddr_q;
  assign mem_wdata    = wdata_q;

endmodule
